// File: rtl/control_sequencer.sv
// control_sequencer: hardwired fetch/decode/execute sequencer for the ALU datapath system.
// Optional build macro: CU_SINGLE_STEP_EN adds a Step input and a WAIT state in front of
// every instruction fetch. With the macro undefined the sequencer free-runs.
module control_sequencer #(
  parameter int unsigned RST_CLR_CYCLES = 1
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Run,
`ifdef CU_SINGLE_STEP_EN
  input  logic        Step,
`endif
  input  logic [15:0] IROut,
  input  logic [3:0]  ALUOutFlag,
  output logic [2:0]  RF_OutASel,
  output logic [2:0]  RF_OutBSel,
  output logic [1:0]  RF_FunSel,
  output logic [1:0]  ARF_FunSel,
  output logic [3:0]  RF_RSel,
  output logic [3:0]  RF_TSel,
  output logic [3:0]  ARF_RegSel,
  output logic [1:0]  ARF_OutCSel,
  output logic [1:0]  ARF_OutDSel,
  output logic        IR_LH,
  output logic        IR_Enable,
  output logic [1:0]  IR_Funsel,
  output logic        Mem_WR,
  output logic        Mem_CS,
  output logic [1:0]  MuxASel,
  output logic [1:0]  MuxBSel,
  output logic        MuxCSel,
  output logic [3:0]  ALU_FunSel,
  output logic        Halted
);

  typedef enum logic [2:0] {
    StRstClr,
    StFetchL,
    StFetchH,
    StExec1,
    StExec2,
`ifdef CU_SINGLE_STEP_EN
    StWait,
`endif
    StHalt
  } stateT;

  localparam logic [3:0] OpLdi = 4'h1;
  localparam logic [3:0] OpLd  = 4'h2;
  localparam logic [3:0] OpSt  = 4'h3;
  localparam logic [3:0] OpAlu = 4'h4;
  localparam logic [3:0] OpBra = 4'h5;
  localparam logic [3:0] OpBeq = 4'h6;
  localparam logic [3:0] OpHlt = 4'hF;

  // Last value of the clear-phase counter before moving on to fetch.
  localparam logic [1:0] ClrLast = 2'(RST_CLR_CYCLES - 1);

  // Where every completed instruction (and the reset clear) hands over to.
`ifdef CU_SINGLE_STEP_EN
  localparam stateT FetchEntry = StWait;
`else
  localparam stateT FetchEntry = StFetchL;
`endif

  stateT      stateQ, stateD;
  logic [1:0] clrCntQ, clrCntD;
  logic       zFlagQ, zFlagD;

  logic [3:0] op;
  logic [1:0] rd;
  logic [1:0] rs;
  logic [3:0] aluFn;
  logic [3:0] rdOneHot;

  assign op       = IROut[15:12];
  assign rd       = IROut[11:10];
  assign rs       = IROut[9:8];
  assign aluFn    = IROut[7:4];
  // R1 lives in bit 3, so Rd=0 maps to 1000.
  assign rdOneHot = 4'b1000 >> rd;

  // Address low nibble and the C/N/O flags are not decoded by the sequencer.
  logic unusedBits;
  assign unusedBits = ^{IROut[3:0], ALUOutFlag[2:0]};

  // State, clear counter and registered Z flag.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      stateQ  <= StRstClr;
      clrCntQ <= '0;
      zFlagQ  <= 1'b0;
    end else begin
      stateQ  <= stateD;
      clrCntQ <= clrCntD;
      zFlagQ  <= zFlagD;
    end
  end

  // Next-state logic, clear-phase counting and Z capture at the end of an ALU op.
  always_comb begin
    stateD  = stateQ;
    clrCntD = clrCntQ;
    zFlagD  = zFlagQ;
    case (stateQ)
      StRstClr: begin
        if (clrCntQ == ClrLast) begin
          stateD  = FetchEntry;
          clrCntD = '0;
        end else begin
          clrCntD = clrCntQ + 2'd1;
        end
      end
      StFetchL: stateD = StFetchH;
      StFetchH: stateD = StExec1;
      StExec1: begin
        case (op)
          OpLd, OpSt: stateD = StExec2;
          OpHlt:      stateD = StHalt;
          default:    stateD = FetchEntry;
        endcase
        if (op == OpAlu) begin
          zFlagD = ALUOutFlag[3];
        end
      end
      StExec2: stateD = FetchEntry;
      StHalt: begin
        if (Run) begin
          stateD = FetchEntry;
        end
      end
`ifdef CU_SINGLE_STEP_EN
      StWait: begin
        if (Step) begin
          stateD = StFetchL;
        end
      end
`endif
      default: stateD = StRstClr;
    endcase
  end

  // Moore output decode from state and IROut; idle vector whenever Reset is high.
  always_comb begin
    RF_OutASel  = 3'b000;
    RF_OutBSel  = 3'b000;
    RF_FunSel   = 2'b00;
    ARF_FunSel  = 2'b00;
    RF_RSel     = 4'b0000;
    RF_TSel     = 4'b0000;
    ARF_RegSel  = 4'b0000;
    ARF_OutCSel = 2'b00;
    ARF_OutDSel = 2'b00;
    IR_LH       = 1'b0;
    IR_Enable   = 1'b0;
    IR_Funsel   = 2'b00;
    Mem_WR      = 1'b0;
    Mem_CS      = 1'b1;
    MuxASel     = 2'b00;
    MuxBSel     = 2'b00;
    MuxCSel     = 1'b0;
    ALU_FunSel  = 4'b0000;
    Halted      = 1'b0;
    if (!Reset) begin
      case (stateQ)
        StRstClr: begin
          ARF_RegSel = 4'b1110;
          ARF_FunSel = 2'b11;
          RF_RSel    = 4'b1111;
          RF_FunSel  = 2'b11;
        end
        StFetchL, StFetchH: begin
          // Read memory at PC into one IR half, then bump PC.
          ARF_OutDSel = 2'b10;
          Mem_CS      = 1'b0;
          IR_Enable   = 1'b1;
          IR_Funsel   = 2'b10;
          IR_LH       = (stateQ == StFetchH);
          ARF_RegSel  = 4'b1000;
          ARF_FunSel  = 2'b01;
        end
        StExec1: begin
          case (op)
            OpLdi: begin
              MuxASel   = 2'b10;
              RF_RSel   = rdOneHot;
              RF_FunSel = 2'b10;
            end
            OpLd, OpSt: begin
              // AR <= IR[7:0]
              MuxBSel    = 2'b10;
              ARF_RegSel = 4'b0100;
              ARF_FunSel = 2'b10;
            end
            OpAlu: begin
              RF_OutASel = {1'b0, rs};
              MuxCSel    = 1'b0;
              ALU_FunSel = aluFn;
              MuxASel    = 2'b00;
              RF_RSel    = rdOneHot;
              RF_FunSel  = 2'b10;
            end
            OpBra: begin
              MuxBSel    = 2'b10;
              ARF_RegSel = 4'b1000;
              ARF_FunSel = 2'b10;
            end
            OpBeq: begin
              if (zFlagQ) begin
                MuxBSel    = 2'b10;
                ARF_RegSel = 4'b1000;
                ARF_FunSel = 2'b10;
              end
            end
            default: ;
          endcase
        end
        StExec2: begin
          if (op == OpLd) begin
            ARF_OutDSel = 2'b00;
            Mem_CS      = 1'b0;
            MuxASel     = 2'b01;
            RF_RSel     = rdOneHot;
            RF_FunSel   = 2'b10;
          end else if (op == OpSt) begin
            // Rd passes through the ALU unchanged onto the memory data bus.
            ARF_OutDSel = 2'b00;
            RF_OutASel  = {1'b0, rd};
            MuxCSel     = 1'b0;
            ALU_FunSel  = 4'b0000;
            Mem_CS      = 1'b0;
            Mem_WR      = 1'b1;
          end
        end
        StHalt: Halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule
